// File: rtl/block_program_loader_pkg.sv
// Shared definitions for the block program loader: command opcodes,
// write-target encodings and controller states.
package block_program_loader_pkg;

    localparam logic [7:0] LDR_NOP      = 8'h00;
    localparam logic [7:0] LDR_WR_INSTR = 8'h01;
    localparam logic [7:0] LDR_WR_REG   = 8'h02;
    localparam logic [7:0] LDR_SET_N    = 8'h03;

    typedef enum logic [1:0] {
        TGT_INSTR = 2'd0,
        TGT_REG0  = 2'd1,
        TGT_REG1  = 2'd2
    } wr_target_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SEL,
        S_DATA,
        S_EXEC
    } state_e;

    typedef enum logic [1:0] {
        CMD_INSTR,
        CMD_REG,
        CMD_SET_N
    } cmd_e;

    function automatic wr_target_e reg_target(input logic sel);
        return sel ? TGT_REG1 : TGT_REG0;
    endfunction

endpackage

// File: rtl/block_program_loader_if.sv
// Host byte stream and memory write request channel of the loader.
interface block_program_loader_if #(
    parameter int unsigned AW = 8
);
    import block_program_loader_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             wr_valid;
    logic             wr_ready;
    wr_target_e       wr_target;
    logic [AW-1:0]    wr_addr;
    logic [31:0]      wr_data;

    modport master (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_valid, wr_target, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_valid, wr_target, wr_addr, wr_data
    );

endinterface

// File: rtl/block_program_loader_byte_assembler.sv
// Big-endian payload assembler: shifts bytes in MSB first and counts
// down the bytes remaining in the current payload.
module byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [2:0]  load_count,
    input  logic        shift_en,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        done
);

    // Only 24 bits are stored; the incoming byte completes the 32-bit word.
    logic [23:0] shreg;
    logic [2:0]  count;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= '0;
            count <= load_count;
        end else if (shift_en) begin
            shreg <= {shreg[15:0], in_data};
            count <= count - 3'd1;
        end
    end

    always_comb begin
        word = {shreg, in_data};
        done = shift_en && (count == 3'd1);
    end

endmodule

// File: rtl/block_program_loader.sv
// Write side of the block program store: decodes the host command stream
// and issues single-word instruction/register writes.
module block_program_loader
    import block_program_loader_pkg::*;
#(
    parameter int unsigned data_width = 16,
    parameter int unsigned n_blocks   = 256,
    localparam int unsigned AW = (n_blocks > 1) ? $clog2(n_blocks) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    block_program_loader_if.slave bus,
    output logic [AW-1:0]         n_blocks_running,
    output logic                  cmd_error
);

    localparam logic [2:0] REG_BYTES = 3'(data_width / 8);

    state_e        state;
    cmd_e          cmd;
    logic          sel;
    logic          discard;
    logic [AW-1:0] addr_q;

    logic          take;
    logic          asm_load;
    logic [2:0]    asm_count;
    logic          asm_shift;
    logic [31:0]   asm_word;
    logic          asm_done;

    always_comb begin
        take      = bus.in_valid && bus.in_ready;
        asm_load  = take && (state == S_ADDR) && (cmd != CMD_SET_N);
        asm_count = (cmd == CMD_INSTR) ? 3'd4 : REG_BYTES;
        asm_shift = take && (state == S_DATA);
    end

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .load       (asm_load),
        .load_count (asm_count),
        .shift_en   (asm_shift),
        .in_data    (bus.in_data),
        .word       (asm_word),
        .done       (asm_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            cmd              <= CMD_INSTR;
            sel              <= 1'b0;
            discard          <= 1'b0;
            addr_q           <= '0;
            bus.in_ready     <= 1'b1;
            bus.wr_valid     <= 1'b0;
            bus.wr_target    <= TGT_INSTR;
            bus.wr_addr      <= '0;
            bus.wr_data      <= '0;
            n_blocks_running <= '0;
            cmd_error        <= 1'b0;
        end else begin
            cmd_error <= 1'b0;
            case (state)
                S_IDLE: if (take) begin
                    case (bus.in_data)
                        LDR_WR_INSTR: begin cmd <= CMD_INSTR; state <= S_ADDR; end
                        LDR_WR_REG:   begin cmd <= CMD_REG;   state <= S_ADDR; end
                        LDR_SET_N:    begin cmd <= CMD_SET_N; state <= S_ADDR; end
                        LDR_NOP:      state <= S_IDLE;
                        default:      cmd_error <= 1'b1;
                    endcase
                end
                S_ADDR: if (take) begin
                    addr_q  <= bus.in_data[AW-1:0];
                    discard <= (32'(bus.in_data) >= n_blocks);
                    case (cmd)
                        CMD_SET_N: begin
                            if (32'(bus.in_data) < n_blocks)
                                n_blocks_running <= bus.in_data[AW-1:0];
                            else
                                cmd_error <= 1'b1;
                            state <= S_IDLE;
                        end
                        CMD_REG: state <= S_SEL;
                        default: state <= S_DATA;
                    endcase
                end
                S_SEL: if (take) begin
                    sel   <= bus.in_data[0];
                    state <= S_DATA;
                end
                S_DATA: if (asm_done) begin
                    // Out-of-range payloads are fully consumed before the reject.
                    if (discard) begin
                        cmd_error <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        bus.wr_valid  <= 1'b1;
                        bus.in_ready  <= 1'b0;
                        bus.wr_target <= (cmd == CMD_INSTR) ? TGT_INSTR : reg_target(sel);
                        bus.wr_addr   <= addr_q;
                        bus.wr_data   <= asm_word;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: if (bus.wr_ready) begin
                    bus.wr_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_program_loader.sv
// Directed bench for block_program_loader (16-bit registers, 8 block slots).
module tb_block_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] n_blocks_running;
    logic       cmd_error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int err_seen = 0;

    logic [31:0] wq_data[$];
    logic [2:0]  wq_addr[$];
    logic [1:0]  wq_tgt[$];
    int          wq_cyc[$];

    block_program_loader_if #(.AW(3)) bus ();

    block_program_loader #(
        .data_width (16),
        .n_blocks   (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave),
        .n_blocks_running (n_blocks_running),
        .cmd_error        (cmd_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.wr_valid && bus.wr_ready) begin
                wq_data.push_back(bus.wr_data);
                wq_addr.push_back(bus.wr_addr);
                wq_tgt.push_back(bus.wr_target);
                wq_cyc.push_back(cyc);
            end
            if (cmd_error) err_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send_seq(input byte_q_t s);
        foreach (s[i]) send_byte(s[i]);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t seq;
        int base;
        int e0;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_wr_target", 32'(bus.wr_target), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_nbr", 32'(n_blocks_running), 32'd0);
        check("rst_cmd_error", 32'(cmd_error), 32'd0);

        // Instruction write, no backpressure
        seq = '{8'h01, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_seq(seq);
        check("instr_wr_valid", 32'(bus.wr_valid), 32'd1);
        check("instr_in_ready", 32'(bus.in_ready), 32'd0);
        check("instr_target", 32'(bus.wr_target), 32'd0);
        check("instr_addr", 32'(bus.wr_addr), 32'd5);
        check("instr_data", bus.wr_data, 32'hDEADBEEF);
        tick();
        check("instr_wr_valid_after", 32'(bus.wr_valid), 32'd0);
        check("instr_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("instr_wr_count", 32'(wq_data.size()), 32'd1);

        // Register write held by backpressure, stray byte offered meanwhile
        bus.wr_ready = 1'b0;
        e0 = err_seen;
        seq = '{8'h02, 8'h03, 8'h01, 8'h12, 8'h34};
        send_seq(seq);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7F;
        for (int i = 0; i < 4; i++) begin
            check("stall_wr_valid", 32'(bus.wr_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_target", 32'(bus.wr_target), 32'd2);
            check("stall_addr", 32'(bus.wr_addr), 32'd3);
            check("stall_data", bus.wr_data, 32'h00001234);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;
        tick();
        check("reg_wr_valid_after", 32'(bus.wr_valid), 32'd0);
        check("reg_wr_count", 32'(wq_data.size()), 32'd2);
        check("reg_q_data", wq_data[1], 32'h00001234);
        check("reg_q_target", 32'(wq_tgt[1]), 32'd2);
        tick();
        check("stall_byte_not_taken", 32'(err_seen - e0), 32'd0);

        // Block count: valid then out of range
        seq = '{8'h03, 8'h04};
        send_seq(seq);
        check("setn_value", 32'(n_blocks_running), 32'd4);
        check("setn_no_error", 32'(cmd_error), 32'd0);
        seq = '{8'h03, 8'h09};
        send_seq(seq);
        check("setn_bad_error", 32'(cmd_error), 32'd1);
        check("setn_bad_keep", 32'(n_blocks_running), 32'd4);
        tick();
        check("setn_error_pulse", 32'(cmd_error), 32'd0);

        // Bad opcode, then bad address, then recovery
        seq = '{8'h7F};
        send_seq(seq);
        check("badop_error", 32'(cmd_error), 32'd1);
        check("badop_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("badop_pulse", 32'(cmd_error), 32'd0);
        base = wq_data.size();
        seq = '{8'h01, 8'h0A, 8'hAA, 8'hBB, 8'hCC};
        send_seq(seq);
        check("badaddr_early_error", 32'(cmd_error), 32'd0);
        seq = '{8'hDD};
        send_seq(seq);
        check("badaddr_error", 32'(cmd_error), 32'd1);
        check("badaddr_no_write", 32'(bus.wr_valid), 32'd0);
        seq = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_seq(seq);
        check("recover_addr", 32'(bus.wr_addr), 32'd0);
        check("recover_data", bus.wr_data, 32'h01020304);
        tick();
        check("recover_wr_count", 32'(wq_data.size() - base), 32'd1);

        // Reset mid-command
        base = wq_data.size();
        seq = '{8'h01, 8'h02, 8'hAA};
        send_seq(seq);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_nbr", 32'(n_blocks_running), 32'd0);
        check("midrst_wr_valid", 32'(bus.wr_valid), 32'd0);
        seq = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(seq);
        check("midrst_addr", 32'(bus.wr_addr), 32'd2);
        check("midrst_data", bus.wr_data, 32'h11223344);
        tick();
        check("midrst_wr_count", 32'(wq_data.size() - base), 32'd1);

        // Back-to-back instruction writes at full input rate
        base = wq_data.size();
        seq = '{8'h01, 8'h06, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                8'h01, 8'h07, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        send_seq(seq);
        repeat (3) tick();
        check("b2b_wr_count", 32'(wq_data.size() - base), 32'd2);
        if (wq_data.size() - base == 2) begin
            check("b2b_addr0", 32'(wq_addr[base]), 32'd6);
            check("b2b_data0", wq_data[base], 32'hA1A2A3A4);
            check("b2b_addr1", 32'(wq_addr[base+1]), 32'd7);
            check("b2b_data1", wq_data[base+1], 32'hB1B2B3B4);
            check("b2b_spacing", 32'(wq_cyc[base+1] - wq_cyc[base]), 32'd7);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/block_program_loader.md
# block_program_loader

Write side of the block program store. Accepts a big-endian byte command stream from the host link, assembles 32-bit instruction words and per-block register values, and issues single-word writes into the instruction memory and block register file that the block fetch/decode pipeline reads. Owns the `n_blocks_running` register that bounds the fetcher's round-robin scan.

## Interface

**Parameters**
- `data_width`, 16: block register width. Must be a multiple of 8, at most 32.
- `n_blocks`, 256: number of block slots. Must be at most 256. `AW = $clog2(n_blocks)`.

**Ports**
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: command byte valid.
- `in_ready`  out  1: loader accepts a byte. A byte is taken when `in_valid & in_ready`.
- `in_data`  in  8: command byte.
- `wr_valid`  out  1: memory write request pending.
- `wr_ready`  in  1: memory arbiter accepts the write this cycle.
- `wr_target`  out  2: write target. 0 = instruction, 1 = register 0, 2 = register 1.
- `wr_addr`  out  AW: block index.
- `wr_data`  out  32: instruction word, or register value zero-extended from `data_width`.
- `n_blocks_running`  out  AW: number of active blocks; 0 halts the fetcher.
- `cmd_error`  out  1: one-cycle pulse when a command is rejected.

## Operation

**Commands.** Each command is an opcode byte, then an address or count byte, then a payload, sent MSB first.
- `0x01 WR_INSTR`: addr, then 4 payload bytes.
- `0x02 WR_REG`: addr, then a sel byte (bit 0 selects register 0 or 1, other bits ignored), then `data_width/8` payload bytes.
- `0x03 SET_N`: a count byte. No write is issued.
- `0x00 NOP`: opcode only.

**States.** IDLE → ADDR → (SEL) → DATA → EXEC → IDLE.
- IDLE: the byte is the opcode.
  - 0x01 or 0x02 → ADDR.
  - 0x03 → ADDR, in count mode.
  - 0x00 → stays in IDLE.
  - Any other value → pulse `cmd_error`, stay in IDLE.
- ADDR: latch the byte.
  - SET_N: if count < n_blocks, update `n_blocks_running` on the next edge; otherwise pulse `cmd_error`. Either way → IDLE.
  - WR_REG → SEL.
  - WR_INSTR → DATA. The byte counter loads 4 for an instruction or `data_width/8` for a register.
  - Address ≥ n_blocks: set a discard flag. The payload is still consumed.
- SEL: latch bit 0 → DATA.
- DATA: shift in one byte per accepted byte: `shreg <= {shreg[23:0], in_data}`. The counter decrements. After the last byte:
  - with the discard flag set: pulse `cmd_error`, go to IDLE, issue no write;
  - otherwise go to EXEC.
- EXEC: `wr_valid = 1` with stable `wr_target`/`wr_addr`/`wr_data` until `wr_ready`. On the handshake edge → IDLE.

**Handshake.** `in_ready = 1` in every state except EXEC.

**Reset.**
- Reset values: `in_ready = 1` (IDLE), `wr_valid = 0`, `wr_target = 0`, `wr_addr = 0`, `wr_data = 0`, `n_blocks_running = 0`, `cmd_error = 0`.
- State → IDLE, shift register and counter cleared.
- Reset mid-command abandons the command with no write. A pending EXEC write is dropped.

## Timing

- The final payload byte is accepted at edge t. `wr_valid` is high in the cycle after t.
  - `wr_ready` high in that cycle: write completes at edge t+1, and `in_ready` is high in the next cycle (one bubble).
- `n_blocks_running` changes one edge after the SET_N count byte is accepted. It holds until the next valid SET_N or reset.
- `cmd_error` is high for exactly one cycle after the offending byte is accepted. The error never stalls the input.
- With `wr_ready = 0`, EXEC holds indefinitely. Outputs stay stable and no input byte is taken.
- A `wr_ready` pulse outside EXEC has no effect.
- Minimum command time at full input rate:
  - WR_INSTR: 6 bytes + 1 EXEC cycle.
  - WR_REG at 16-bit width: 5 bytes + 1 cycle.

## Structure

- A shared header `loader.vh` holds the opcode constants (`LDR_NOP`, `LDR_WR_INSTR`, `LDR_WR_REG`, `LDR_SET_N`), the `wr_target` encodings, and the state encodings.
- One sub-module, `byte_assembler`:
  - an 8-bit-in, 32-bit shift register with a load/decrement byte counter;
  - outputs `done` when the counter reaches zero.
- The FSM, discard flag and `n_blocks_running` register stay in the top module.

## Test plan

- **Instruction write.** Stream 01 05 DE AD BE EF with `wr_ready` = 1 → one `wr_valid` cycle with target 0, addr 5, data 0xDEADBEEF. `in_ready` is low for exactly that cycle.
- **Register write with backpressure.** Stream 02 03 01 12 34 with `wr_ready` low for 4 cycles → target 2, addr 3, data 0x00001234 held stable throughout; a byte offered during the stall is not taken.
- **Block count.** Stream 03 04 → `n_blocks_running` becomes 4 one edge later. With `n_blocks` = 8, stream 03 09 → `cmd_error` pulse and the count is unchanged.
- **Bad opcode and bad address.** Byte 0x7F → `cmd_error` pulse, no state change. With `n_blocks` = 8, stream 01 0A + 4 bytes → `cmd_error` after the 4th payload byte and no write. The next command 01 00 … executes normally.
- **Reset mid-command.** Assert `reset` after 01 02 AA → no write. `n_blocks_running` = 0. A following 01 02 11 22 33 44 writes 0x11223344 to addr 2.
- **Back-to-back commands.** Two WR_INSTR commands with `in_valid` held high → two writes, 7 cycles apart, with correct data and no dropped bytes.
